bits_div: RTL and testbench

//   Sequential restoring divider, the inverse of the 8x8 shift-add multiplier (bits_mul).

---
 rtl/bits_div.sv | 129 ++++++++++++
 tb/tb_bits_div.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bits_div.sv
// bits_div: sequential restoring divider, 2W-bit dividend / W-bit divisor.
// Produces one quotient bit per clock, MSB first. It uses a start/done handshake.
// Quotient, remainder and the divide-by-zero flag are registered.
// They change only on the edge that raises done.
// Optional macro BITS_DIV_FAST_EN: when dividend < divisor the result is known at start.
// The divider then skips the bit-serial loop. The results are the same, only the latency is shorter.
module bits_div #(
   parameter int W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2*W-1:0]   dividend,
   input  logic [W-1:0]     divisor,
   output logic             busy,
   output logic             done,
   output logic [2*W-1:0]   quotient,
   output logic [W-1:0]     remainder,
   output logic             dbz
);

   localparam int CW = $clog2(2*W) + 1;
   localparam logic [CW-1:0] LAST = CW'(2*W);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]     state;
   logic [CW-1:0]  cnt;
   logic           zero_r;
   logic           fast_r;

   logic [2*W-1:0] dvd_r;
   logic [W-1:0]   dvs_r;
   logic [W-1:0]   rem_r;
   logic [2*W-1:0] q_r;

   logic           accept;
   logic           fast_hit;
   logic [W:0]     r_shift;
   logic           r_ge;
   logic [W-1:0]   r_sub;

   assign accept = start && (state == S_IDLE);
   assign busy   = (state != S_IDLE);

`ifdef BITS_DIV_FAST_EN
   assign fast_hit = (divisor != '0) && (dividend < {{W{1'b0}}, divisor});
`else
   assign fast_hit = 1'b0;
`endif

   // One restoring step: shift the next dividend bit in, then subtract when it fits
   always_comb begin
      r_shift = {rem_r, dvd_r[2*W-1]};
      r_ge    = (r_shift >= {1'b0, dvs_r});
      r_sub   = r_shift[W-1:0] - dvs_r;
   end

   // Control FSM, step counter and registered results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         zero_r    <= 1'b0;
         fast_r    <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         dbz       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state  <= S_CALC;
                  zero_r <= (divisor == '0);
                  fast_r <= fast_hit;
                  // Trivial results bypass the loop by starting the counter at its end
                  cnt    <= ((divisor == '0) || fast_hit) ? LAST : '0;
               end
            end
            S_CALC: begin
               if (cnt == LAST) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  if (zero_r) begin
                     quotient  <= '1;
                     remainder <= '0;
                     dbz       <= 1'b1;
                  end else if (fast_r) begin
                     quotient  <= '0;
                     remainder <= dvd_r[W-1:0];
                     dbz       <= 1'b0;
                  end else begin
                     quotient  <= q_r;
                     remainder <= rem_r;
                     dbz       <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Operand capture and bit-serial datapath (no reset needed on data)
   always_ff @(posedge clk) begin
      if (accept) begin
         dvd_r <= dividend;
         dvs_r <= divisor;
         rem_r <= '0;
         q_r   <= '0;
      end else if ((state == S_CALC) && (cnt != LAST)) begin
         rem_r <= r_ge ? r_sub : r_shift[W-1:0];
         q_r   <= {q_r[2*W-2:0], r_ge};
         dvd_r <= {dvd_r[2*W-2:0], 1'b0};
      end
   end

endmodule

// File: tb/tb_bits_div.sv
// tb_bits_div: directed and random checks of bits_div.
// A behavioural model works from plain division and the documented latency.
// It is compared against the DUT on every cycle.
// Literal expectations for the documented vectors pin the model itself.
module tb_bits_div;

   localparam int W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [2*W-1:0]   dividend = '0;
   logic [W-1:0]     divisor = '0;
   logic             busy;
   logic             done;
   logic [2*W-1:0]   quotient;
   logic [W-1:0]     remainder;
   logic             dbz;

   int  nchk = 0;
   int  nfail = 0;
   bit  chk_en = 1'b0;
   int  cyc = 0;

   always #5 clk = ~clk;

   bits_div #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural model: result from / and %, done after the documented latency
   bit             m_busy = 1'b0;
   bit             m_done = 1'b0;
   bit             m_dbz  = 1'b0;
   logic [2*W-1:0] m_q = '0;
   logic [W-1:0]   m_r = '0;
   bit             p_dbz;
   logic [2*W-1:0] p_q;
   logic [W-1:0]   p_r;
   int             m_done_at = 0;

   function automatic int exp_lat(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
      if (dvs == 0) return 1;
`ifdef BITS_DIV_FAST_EN
      if (dvd < {{W{1'b0}}, dvs}) return 1;
`endif
      return 2*W + 1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_q    = '0;
         m_r    = '0;
         m_dbz  = 1'b0;
      end else begin
         m_done = 1'b0;
         if (!m_busy) begin
            if (start) begin
               m_busy = 1'b1;
               if (divisor == 0) begin
                  p_q = '1; p_r = '0; p_dbz = 1'b1;
               end else begin
                  p_q   = dividend / {{W{1'b0}}, divisor};
                  p_r   = W'(dividend % {{W{1'b0}}, divisor});
                  p_dbz = 1'b0;
               end
               m_done_at = cyc + exp_lat(dividend, divisor);
            end
         end else if (cyc == m_done_at) begin
            m_done = 1'b1;
            m_q    = p_q;
            m_r    = p_r;
            m_dbz  = p_dbz;
         end else if (cyc == m_done_at + 1) begin
            m_busy = 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      nchk++;
      if (act !== expv) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",      32'(busy),      32'(m_busy));
         chk("done",      32'(done),      32'(m_done));
         chk("quotient",  32'(quotient),  32'(m_q));
         chk("remainder", 32'(remainder), 32'(m_r));
         chk("dbz",       32'(dbz),       32'(m_dbz));
      end
   end

   // Issue one operation and wait (bounded) for done; lat = edges from start to done
   task automatic do_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, output int lat);
      int c0;
      bit got;
      @(negedge clk);
      #1;
      dividend = dvd;
      divisor  = dvs;
      start    = 1'b1;
      @(negedge clk);
      c0 = cyc;
      #1;
      start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1'b1;
      end
      if (got) begin
         lat = cyc - c0;
      end else begin
         lat = -1;
         nchk++;
         nfail++;
         $display("FAIL done_timeout: got no done, expected done within 40 cycles");
      end
      @(negedge clk);
   endtask

   initial begin
      int lat;
      int ndone;
      logic [2*W-1:0] rd;
      logic [W-1:0]   rv;

      // Test 1: reset held 5 cycles
      #1 rst = 1'b1;
      #1 chk_en = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_done", 32'(done), 32'd0);
      chk("t1_q",    32'(quotient), 32'd0);
      chk("t1_r",    32'(remainder), 32'd0);
      chk("t1_dbz",  32'(dbz), 32'd0);

      // Test 2: exact division
      do_op(16'h1323, 8'h45, lat);
      chk("t2_lat", 32'(lat), 32'd17);
      chk("t2_q",   32'(quotient), 32'h0047);
      chk("t2_r",   32'(remainder), 32'h00);
      chk("t2_dbz", 32'(dbz), 32'd0);

      // Test 3: nonzero remainder, full-width quotient
      do_op(16'h1330, 8'h45, lat);
      chk("t3a_q", 32'(quotient), 32'h0047);
      chk("t3a_r", 32'(remainder), 32'h0D);
      do_op(16'hFFFF, 8'h01, lat);
      chk("t3b_q", 32'(quotient), 32'hFFFF);
      chk("t3b_r", 32'(remainder), 32'h00);
      chk("t3b_lat", 32'(lat), 32'd17);

      // Test 4: divide by zero, then dbz cleared by a normal op
      do_op(16'h1234, 8'h00, lat);
      chk("t4_lat", 32'(lat), 32'd1);
      chk("t4_q",   32'(quotient), 32'hFFFF);
      chk("t4_r",   32'(remainder), 32'h00);
      chk("t4_dbz", 32'(dbz), 32'd1);
      do_op(16'h1323, 8'h45, lat);
      chk("t4b_dbz", 32'(dbz), 32'd0);
      chk("t4b_q",   32'(quotient), 32'h0047);

      // Test 5: start while busy is ignored, reset mid-operation aborts
      @(negedge clk);
      #1 dividend = 16'h1323; divisor = 8'h45; start = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      #1 dividend = 16'h0100; divisor = 8'h03; start = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
      chk("t5_busy_mid", 32'(busy), 32'd1);
      repeat (4) @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("t5_q",    32'(quotient), 32'd0);
      chk("t5_r",    32'(remainder), 32'd0);
      chk("t5_dbz",  32'(dbz), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("t5_nodone", 32'(ndone), 32'd0);
      do_op(16'h1323, 8'h45, lat);
      chk("t5b_q", 32'(quotient), 32'h0047);
      chk("t5b_r", 32'(remainder), 32'h00);

      // Test 6: dividend smaller than divisor
      do_op(16'h0030, 8'h45, lat);
      chk("t6_q", 32'(quotient), 32'h0000);
      chk("t6_r", 32'(remainder), 32'h30);
`ifdef BITS_DIV_FAST_EN
      chk("t6_lat", 32'(lat), 32'd1);
`else
      chk("t6_lat", 32'(lat), 32'd17);
`endif

      // Random operands checked against the arithmetic invariant
      for (int k = 0; k < 24; k++) begin
         rv = W'($urandom_range(0, 255));
         if (k % 8 == 0) rv = '0;
         if (k % 8 == 1) rv = 8'h01;
         rd = (2*W)'($urandom);
         if (k % 4 == 3) rd = (2*W)'($urandom_range(0, 32'(rv)));
         do_op(rd, rv, lat);
         chk("rnd_lat", 32'(lat), 32'(exp_lat(rd, rv)));
         if (rv != 0) begin
            chk("rnd_inv", 32'(quotient) * 32'(rv) + 32'(remainder), 32'(rd));
            chk("rnd_rlt", 32'(remainder < rv), 32'd1);
         end else begin
            chk("rnd_dbz", 32'(dbz), 32'd1);
         end
      end

      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
      $finish;
   end

endmodule
